aud_i2s_rx: RTL and testbench

- I2S receiver for the WM8731 ADC path. It is the capture-side counterpart of the DAC-side audio player.
- Oversamples BCLK/ADCLRCK/ADCDAT from the codec in the 12 MHz system domain and deserialises 16-bit left/right samples.
- Emits one stereo sample per frame with a one-cycle valid, plus the SRAM word address at which the recorder stores it.
- Controlled by the debounced record/pause/stop key pulses from the top controller.

---
 rtl/aud_i2s_rx.sv | 199 +++++++++++++++++++
 tb/tb_aud_i2s_rx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aud_i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : aud_i2s_rx
// Brief    : I2S capture receiver for the WM8731 ADC path. Oversamples the
//            codec lines in the system clock domain and emits stereo samples
//            with the SRAM word address at which they are stored.
// Revision : 1.0 - initial release
// ============================================================================
module aud_i2s_rx #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 20,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_AUD_BCLK,
    input  logic              i_AUD_ADCLRCK,
    input  logic              i_AUD_ADCDAT,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_full,
    output logic              o_frame_err,
    output logic [1:0]        o_state
);

    localparam int               CNT_W      = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_RECORD = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_bclk_s1, r_bclk_s2, r_bclk_s3;
    logic r_lrck_s1, r_lrck_s2;
    logic r_dat_s1,  r_dat_s2;
    logic r_lrck_prev;

    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_left_hold;
    logic [CNT_W-1:0]  r_bit_cnt;

    logic w_bclk_rise;
    logic w_boundary;
    logic w_fall_bnd;
    logic w_rise_bnd;
    logic w_cnt_full;
    logic w_last_bit;
    logic w_emit;
    logic w_err;
    logic w_latch_left;
    logic w_clear_addr;
    logic w_addr_end;

    assign w_bclk_rise = r_bclk_s2 & ~r_bclk_s3;
    assign w_boundary  = w_bclk_rise & (r_lrck_s2 ^ r_lrck_prev);
    assign w_fall_bnd  = w_boundary & ~r_lrck_s2;
    assign w_rise_bnd  = w_boundary &  r_lrck_s2;
    assign w_cnt_full  = (r_bit_cnt == c_cnt_full);
    assign w_last_bit  = w_bclk_rise & ~w_boundary & (r_bit_cnt == c_cnt_last);
    assign w_addr_end  = o_valid & (o_addr == MAX_ADDR);

    assign o_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_emit       = 1'b0;
        w_err        = 1'b0;
        w_latch_left = 1'b0;
        w_clear_addr = 1'b0;
        if (i_stop) begin
            w_state_nxt  = ST_IDLE;
            w_clear_addr = 1'b1;
        end else if (w_addr_end) begin
            w_state_nxt = ST_IDLE;
        end else if (i_pause && (r_state == ST_RECORD || r_state == ST_ALIGN)) begin
            w_state_nxt = ST_PAUSED;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        w_state_nxt  = ST_ALIGN;
                        w_clear_addr = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (i_start) begin
                        w_state_nxt = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (w_fall_bnd) begin
                        w_state_nxt = ST_RECORD;
                    end
                end
                ST_RECORD: begin
                    // Left half ends at the rising boundary; right half ends
                    // at the falling one, which also opens the next left half.
                    if (w_rise_bnd) begin
                        if (w_cnt_full) begin
                            w_latch_left = 1'b1;
                        end else begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_ALIGN;
                        end
                    end else if (w_fall_bnd) begin
                        w_err = ~w_cnt_full;
                    end else if (w_last_bit && r_lrck_s2) begin
                        w_emit = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bclk_s1   <= 1'b0;
            r_bclk_s2   <= 1'b0;
            r_bclk_s3   <= 1'b0;
            r_lrck_s1   <= 1'b0;
            r_lrck_s2   <= 1'b0;
            r_dat_s1    <= 1'b0;
            r_dat_s2    <= 1'b0;
            r_lrck_prev <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_left_hold <= '0;
            o_left      <= '0;
            o_right     <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_addr      <= '0;
            o_full      <= 1'b0;
        end else begin
            r_bclk_s1 <= i_AUD_BCLK;
            r_bclk_s2 <= r_bclk_s1;
            r_bclk_s3 <= r_bclk_s2;
            r_lrck_s1 <= i_AUD_ADCLRCK;
            r_lrck_s2 <= r_lrck_s1;
            r_dat_s1  <= i_AUD_ADCDAT;
            r_dat_s2  <= r_dat_s1;

            // Boundary rise is the I2S delay slot: clear, do not shift.
            if (w_bclk_rise) begin
                r_lrck_prev <= r_lrck_s2;
                if (w_boundary) begin
                    r_bit_cnt <= '0;
                end else if (!w_cnt_full) begin
                    r_shift   <= {r_shift[DATA_W-2:0], r_dat_s2};
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end

            if (w_latch_left) begin
                r_left_hold <= r_shift;
            end

            o_valid     <= w_emit;
            o_frame_err <= w_err;
            if (w_emit) begin
                o_left  <= r_left_hold;
                o_right <= {r_shift[DATA_W-2:0], r_dat_s2};
            end

            if (w_clear_addr) begin
                o_addr <= '0;
                o_full <= 1'b0;
            end else if (w_addr_end) begin
                o_full <= 1'b1;
            end else if (o_valid) begin
                o_addr <= o_addr + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aud_i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_aud_i2s_rx
// Brief    : Directed bench for aud_i2s_rx with an I2S codec driver model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aud_i2s_rx;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [19:0] a;
    } samp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, pause, stop;
    logic        bclk, lrck, dat;

    logic [15:0] left1, right1, left2, right2;
    logic        valid1, valid2, full1, full2, ferr1, ferr2;
    logic [19:0] addr1, addr2;
    logic [1:0]  state1, state2;

    samp_t q1[$];
    samp_t q2[$];
    int    err1;
    int    total = 0;
    int    bad   = 0;

    aud_i2s_rx dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
        .o_left(left1), .o_right(right1), .o_valid(valid1), .o_addr(addr1),
        .o_full(full1), .o_frame_err(ferr1), .o_state(state1)
    );

    aud_i2s_rx #(.MAX_ADDR(20'd3)) dut_small (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_AUD_BCLK(bclk), .i_AUD_ADCLRCK(lrck), .i_AUD_ADCDAT(dat),
        .o_left(left2), .o_right(right2), .o_valid(valid2), .o_addr(addr2),
        .o_full(full2), .o_frame_err(ferr2), .o_state(state2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid1) q1.push_back('{l: left1, r: right1, a: addr1});
        if (valid2) q2.push_back('{l: left2, r: right2, a: addr2});
        if (ferr1)  err1++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // BCLK = clk/8; LRCK and DAT change on the falling BCLK edge.
    task automatic bit_out(input logic lr, input logic d);
        bclk = 1'b0; lrck = lr; dat = d;
        tick(4);
        bclk = 1'b1;
        tick(4);
    endtask

    task automatic send_half(input logic lr, input logic [15:0] d, input int nbits, input int pad);
        bit_out(lr, 1'b0);
        for (int i = 0; i < nbits; i++) bit_out(lr, d[15-i]);
        for (int i = 0; i < pad; i++) bit_out(lr, 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_half(1'b0, l, 16, 3);
        send_half(1'b1, r, 16, 3);
    endtask

    task automatic pulse(input logic s, input logic p, input logic t);
        start = s; pause = p; stop = t;
        tick(1);
        start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    task automatic chk_one(input string name, input logic [15:0] l, input logic [15:0] r,
                           input logic [19:0] a);
        samp_t s;
        chk({name, "_count"}, q1.size(), 1);
        if (q1.size() > 0) begin
            s = q1.pop_front();
            chk({name, "_left"},  s.l, l);
            chk({name, "_right"}, s.r, r);
            chk({name, "_addr"},  s.a, a);
        end
        q1.delete();
    endtask

    samp_t tbl[4];
    samp_t s2;

    initial begin
        tbl[0] = '{l: 16'hA5C3, r: 16'h3C5A, a: 20'd0};
        tbl[1] = '{l: 16'h0001, r: 16'h8000, a: 20'd1};
        tbl[2] = '{l: 16'hFFFF, r: 16'h0000, a: 20'd2};
        tbl[3] = '{l: 16'h1234, r: 16'hABCD, a: 20'd3};

        rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
        bclk = 1'b0; lrck = 1'b1; dat = 1'b0; err1 = 0;
        tick(3);
        chk("rst_state", state1, 0);
        chk("rst_valid", valid1, 0);
        chk("rst_addr",  addr1, 0);
        chk("rst_left",  left1, 0);
        chk("rst_full",  full1, 0);
        rst_n = 1'b1;
        send_half(1'b1, 16'h0000, 16, 3);

        // Table-driven capture at consecutive addresses
        pulse(1, 0, 0);
        chk("start_state", state1, 1);
        for (int i = 0; i < 4; i++) begin
            q1.delete();
            send_frame(tbl[i].l, tbl[i].r);
            chk_one($sformatf("vec%0d", i), tbl[i].l, tbl[i].r, tbl[i].a);
        end
        chk("addr_after_tbl", addr1, 4);
        chk("rec_state", state1, 2);

        // Start issued mid-right-channel waits for the next falling boundary
        pulse(0, 0, 1);
        chk("stop_addr", addr1, 0);
        send_half(1'b0, 16'h1111, 16, 3);
        bit_out(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) bit_out(1'b1, 1'b1);
        pulse(1, 0, 0);
        chk("mid_start_state", state1, 1);
        for (int i = 0; i < 8; i++) bit_out(1'b1, 1'b1);
        bit_out(1'b1, 1'b0);
        chk("mid_still_align", state1, 1);
        chk("mid_no_valid", q1.size(), 0);
        send_frame(16'h2222, 16'h3333);
        chk_one("mid", 16'h2222, 16'h3333, 20'd0);

        // Short left half-frame
        err1 = 0;
        send_half(1'b0, 16'hABCD, 10, 0);
        send_half(1'b1, 16'h5555, 16, 3);
        chk("short_err", err1, 1);
        chk("short_state", state1, 1);
        chk("short_no_valid", q1.size(), 0);
        send_frame(16'hCAFE, 16'hBEEF);
        chk_one("after_short", 16'hCAFE, 16'hBEEF, 20'd1);

        // Address exhaustion on the small instance
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        q2.delete();
        for (int i = 0; i < 4; i++) send_frame(tbl[i].l, tbl[i].r);
        chk("full_count", q2.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (q2.size() > 0) begin
                s2 = q2.pop_front();
                chk($sformatf("full_addr%0d", i), s2.a, i);
            end
        end
        chk("full_flag", full2, 1);
        chk("full_state", state2, 0);
        chk("full_addr_hold", addr2, 3);
        send_frame(16'h7777, 16'h8888);
        chk("full_no_more", q2.size(), 0);

        // Pause / resume / stop+pause
        pulse(0, 0, 1);
        pulse(1, 0, 0);
        send_frame(16'h0102, 16'h0304);
        send_frame(16'h0506, 16'h0708);
        q1.delete();
        pulse(0, 1, 0);
        chk("pause_state", state1, 3);
        chk("pause_addr", addr1, 2);
        pulse(1, 0, 0);
        chk("resume_state", state1, 1);
        send_frame(16'h9ABC, 16'hDEF0);
        chk_one("resume", 16'h9ABC, 16'hDEF0, 20'd2);
        pulse(0, 1, 1);
        chk("stop_pause_state", state1, 0);
        chk("stop_pause_addr", addr1, 0);

        // Asynchronous reset mid-right-channel
        pulse(1, 0, 0);
        send_frame(16'h4321, 16'h8765);
        q1.delete();
        send_half(1'b0, 16'h1357, 16, 3);
        bit_out(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) bit_out(1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_left",  left1, 0);
        chk("arst_right", right1, 0);
        chk("arst_addr",  addr1, 0);
        chk("arst_state", state1, 0);
        chk("arst_valid", valid1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 11; i++) bit_out(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_frame(16'hFACE, 16'hD00D);
        chk("post_rst_no_valid", q1.size(), 0);
        chk("post_rst_state", state1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
